// File: rtl/seq_div4_if.sv
// seq_div4 request/result bundle: start with operands in, busy/done with quotient, remainder and divide-by-zero flag out.
interface seq_div4_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div4.sv
// seq_div4: restoring divider, one quotient bit per clock, result WIDTH+1 cycles after an accepted start; start ignored while busy.
// Optional SEQDIV_DBZ_EN: a zero divisor skips RUN and reports div_by_zero one cycle after start.
module seq_div4 #(
  parameter int WIDTH = 4
) (
  input logic      clk,
  input logic      rst,
  seq_div4_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p_r;
  logic [WIDTH-1:0] opr_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;

  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] opr_sh;
  logic [WIDTH:0]   b_n;
  logic [WIDTH:0]   pr;
  logic [WIDTH:0]   c;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   p_nxt;
  logic [WIDTH-1:0] opr_nxt;

  logic accept;
  logic last;
  logic dbz_cap;
  logic busy_c;
  logic done_c;

  assign accept = (state != RUN) && bus.start;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

`ifdef SEQDIV_DBZ_EN
  assign dbz_cap = accept && (bus.divisor == '0);
`else
  assign dbz_cap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = dbz_cap ? DONE : RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) state_nxt = dbz_cap ? DONE : RUN;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Trial subtract P_shifted - divisor as P_shifted + ~divisor + 1 with a generate/propagate carry chain.
  always_comb begin
    sh     = {p_r, opr_r} << 1;
    p_sh   = sh[2*WIDTH:WIDTH];
    opr_sh = sh[WIDTH-1:0];
    b_n    = ~{1'b0, dvs_r};
    pr     = p_sh ^ b_n;
    c      = '0;
    c[0]   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = (p_sh[i] & b_n[i]) | (pr[i] & c[i]);
    end
    trial   = pr ^ c;
    p_nxt   = trial[WIDTH] ? p_sh : trial;
    opr_nxt = opr_sh | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
  end

`ifdef SEQDIV_DBZ_EN
  logic dbz_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r   <= '0;
      opr_r <= '0;
      dvs_r <= '0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
`ifdef SEQDIV_DBZ_EN
      dbz_r <= 1'b0;
`endif
    end else if (accept) begin
      p_r   <= '0;
      opr_r <= bus.dividend;
      dvs_r <= bus.divisor;
      cnt   <= '0;
`ifdef SEQDIV_DBZ_EN
      dbz_r <= dbz_cap;
      if (dbz_cap) begin
        quo_r <= '1;
        rem_r <= bus.dividend;
      end
`endif
    end else if (state == RUN) begin
      p_r   <= p_nxt;
      opr_r <= opr_nxt;
      cnt   <= cnt + 1'b1;
      if (last) begin
        quo_r <= opr_nxt;
        rem_r <= p_nxt[WIDTH-1:0];
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
`ifdef SEQDIV_DBZ_EN
  assign bus.div_by_zero = dbz_r;
`else
  assign bus.div_by_zero = 1'b0;
`endif
endmodule
